// File: rtl/packet_builder.sv
// Transmit-side packet serialiser: snapshots Ethernet/IP/TCP headers on start and emits
// them LS-word first, then passes PAYLOAD_WORDS payload words straight through from the FIFO.
module packet_builder #(
    parameter int WIDTH         = 32,
    parameter int PAYLOAD_WORDS = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [127:0]      eth_hdr,
    input  logic [159:0]      ip_hdr,
    input  logic [159:0]      tcp_hdr,
    output logic              busy,
    input  logic [WIDTH-1:0]  pay_data,
    input  logic              pay_valid,
    output logic              pay_ready,
    output logic [WIDTH-1:0]  data_out,
    output logic              valid_out,
    input  logic              ready_out,
    output logic              last_out,
    output logic [15:0]       pkt_count
);

    localparam int HDR_WORDS = 14;
    // Index of the final payload word; needs 9 bits once PAYLOAD_WORDS exceeds 242.
    localparam logic [8:0] LAST_IDX = 9'(HDR_WORDS - 1 + PAYLOAD_WORDS);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ETH  = 3'd1,
        ST_IP   = 3'd2,
        ST_TCP  = 3'd3,
        ST_PAY  = 3'd4
    } state_t;

    state_t       state_q, state_d;
    logic [7:0]   word_idx_q, word_idx_d;
    logic         idx_hi_q, idx_hi_d;
    logic         busy_q, busy_d;
    logic [15:0]  pkt_count_q, pkt_count_d;
    logic [31:0]  hdr_q [0:HDR_WORDS-1];
    logic         load_s;
    logic         is_last_s;
    logic [31:0]  hdr_word_s;
    logic [WIDTH-1:0] hdr_out_s;

    // Header word k of a field, least-significant word first.
    function automatic logic [31:0] word_of160(input logic [159:0] f, input int k);
        return f[32*k +: 32];
    endfunction

    function automatic logic [31:0] word_of128(input logic [127:0] f, input int k);
        return f[32*k +: 32];
    endfunction

    assign is_last_s  = ({idx_hi_q, word_idx_q} == LAST_IDX);
    assign hdr_word_s = hdr_q[word_idx_q[3:0]];

    // Resize the 32-bit header word onto the stream width.
    always_comb begin
        hdr_out_s = '0;
        hdr_out_s = WIDTH'(hdr_word_s);
    end

    // Next-state, word index and handshake outputs.
    always_comb begin
        state_d     = state_q;
        word_idx_d  = word_idx_q;
        idx_hi_d    = idx_hi_q;
        busy_d      = busy_q;
        pkt_count_d = pkt_count_q;
        load_s      = 1'b0;
        valid_out   = 1'b0;
        pay_ready   = 1'b0;
        last_out    = 1'b0;
        data_out    = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load_s     = 1'b1;
                    word_idx_d = 8'd0;
                    idx_hi_d   = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = ST_ETH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ETH, ST_IP, ST_TCP: begin
                valid_out = 1'b1;
                data_out  = hdr_out_s;
                if (ready_out) begin
                    word_idx_d = word_idx_q + 8'd1;
                    if (state_q == ST_ETH && word_idx_q == 8'd3) begin
                        state_d = ST_IP;
                    end else if (state_q == ST_IP && word_idx_q == 8'd8) begin
                        state_d = ST_TCP;
                    end else if (state_q == ST_TCP && word_idx_q == 8'd13) begin
                        state_d = ST_PAY;
                    end else begin
                        state_d = state_q;
                    end
                end else begin
                    word_idx_d = word_idx_q;
                end
            end
            ST_PAY: begin
                // Zero-latency pass-through: the FIFO sees the downstream ready directly.
                valid_out = pay_valid;
                data_out  = pay_data;
                pay_ready = ready_out;
                last_out  = pay_valid && is_last_s;
                if (pay_valid && ready_out) begin
                    if (is_last_s) begin
                        state_d     = ST_IDLE;
                        word_idx_d  = 8'd0;
                        idx_hi_d    = 1'b0;
                        busy_d      = 1'b0;
                        pkt_count_d = pkt_count_q + 16'd1;
                    end else begin
                        {idx_hi_d, word_idx_d} = {idx_hi_q, word_idx_q} + 9'd1;
                    end
                end else begin
                    state_d = ST_PAY;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                word_idx_d = 8'd0;
                idx_hi_d   = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            word_idx_q  <= 8'd0;
            idx_hi_q    <= 1'b0;
            busy_q      <= 1'b0;
            pkt_count_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            word_idx_q  <= word_idx_d;
            idx_hi_q    <= idx_hi_d;
            busy_q      <= busy_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    // Header snapshot, taken only when start is accepted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < HDR_WORDS; k++) begin
                hdr_q[k] <= 32'd0;
            end
        end else if (load_s) begin
            for (int k = 0; k < 4; k++) begin
                hdr_q[k] <= word_of128(eth_hdr, k);
            end
            for (int k = 0; k < 5; k++) begin
                hdr_q[4 + k] <= word_of160(ip_hdr, k);
                hdr_q[9 + k] <= word_of160(tcp_hdr, k);
            end
        end
    end

    assign busy      = busy_q;
    assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_packet_builder.sv
// Randomised and directed bench for packet_builder, checked against a transfer-level
// packet model and a loopback parser that rebuilds the headers from the captured stream.
module tb_packet_builder;

    localparam int W  = 32;
    localparam int PW = 10;
    localparam int NW = 14 + PW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [127:0]  eth_hdr;
    logic [159:0]  ip_hdr;
    logic [159:0]  tcp_hdr;
    logic          busy;
    logic [W-1:0]  pay_data;
    logic          pay_valid;
    logic          pay_ready;
    logic [W-1:0]  data_out;
    logic          valid_out;
    logic          ready_out;
    logic          last_out;
    logic [15:0]   pkt_count;

    always #5 clk = ~clk;

    packet_builder #(.WIDTH(W), .PAYLOAD_WORDS(PW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .eth_hdr(eth_hdr), .ip_hdr(ip_hdr), .tcp_hdr(tcp_hdr),
        .busy(busy), .pay_data(pay_data), .pay_valid(pay_valid), .pay_ready(pay_ready),
        .data_out(data_out), .valid_out(valid_out), .ready_out(ready_out),
        .last_out(last_out), .pkt_count(pkt_count)
    );

    int n_checks = 0;
    int n_errs   = 0;

    // Model state: packet in flight, position in it, snapshot of its headers.
    bit           m_known = 1'b0;
    bit           m_active = 1'b0;
    int           m_pos = 0;
    logic [15:0]  m_pkt = 16'd0;
    logic [127:0] m_eth;
    logic [159:0] m_ip, m_tcp;
    logic [31:0]  m_pay_base = 32'd0;
    logic [31:0]  pay_base_next = 32'hD000_0000;
    logic [31:0]  obs_q[$];
    int pkts_done = 0, accepts = 0, cyc = 0, done_cyc = 0, first_cyc = 0;
    int pay_cnt = 0;

    // Stimulus knobs.
    bit rand_ready = 0, rand_pay = 0, stall_req = 0, gap_req = 0, pulse_req = 0, pulse_on = 0;
    bit rst_req = 0, b2b_mode = 0, chk_span = 0;
    int stall_cnt = 0, gap_cnt = 0, rst_hold = 0, b2b_acc = 0;

    task automatic check_eq(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] exp_hdr(input int k);
        if (k < 4)      return m_eth[32*k +: 32];
        else if (k < 9) return m_ip[32*(k-4) +: 32];
        else            return m_tcp[32*(k-9) +: 32];
    endfunction

    // Loopback parser: rebuild headers from the captured words and compare.
    task automatic parser_check();
        logic [127:0] e;
        logic [159:0] ip, tc;
        check_eq("parse_len", obs_q.size(), NW);
        if (obs_q.size() == NW) begin
            for (int k = 0; k < 4; k++) e[32*k +: 32] = obs_q[k];
            for (int k = 0; k < 5; k++) begin
                ip[32*k +: 32] = obs_q[4 + k];
                tc[32*k +: 32] = obs_q[9 + k];
            end
            check_eq("parse_eth", e, m_eth);
            check_eq("parse_ip", ip, m_ip);
            check_eq("parse_tcp", tc, m_tcp);
            for (int j = 0; j < PW; j++) check_eq("parse_pay", obs_q[14 + j], m_pay_base + 32'(j));
        end
    endtask

    task automatic step();
        bit xfer;
        xfer = 1'b0;
        @(negedge clk);
        cyc++;
        if (m_known) begin
            check_eq("busy", busy, m_active);
            check_eq("pkt_count", pkt_count, m_pkt);
            if (!m_active) begin
                check_eq("idle_valid", valid_out, 1'b0);
                check_eq("idle_pay_ready", pay_ready, 1'b0);
                check_eq("idle_last", last_out, 1'b0);
            end else if (m_pos < 14) begin
                check_eq("hdr_valid", valid_out, 1'b1);
                check_eq("hdr_data", data_out, exp_hdr(m_pos));
                check_eq("hdr_pay_ready", pay_ready, 1'b0);
                check_eq("hdr_last", last_out, 1'b0);
                xfer = ready_out;
            end else begin
                check_eq("pay_valid_out", valid_out, pay_valid);
                check_eq("pay_ready", pay_ready, ready_out);
                check_eq("pay_last", last_out, pay_valid && (m_pos == NW - 1));
                if (pay_valid) check_eq("pay_data", data_out, m_pay_base + 32'(m_pos - 14));
                xfer = pay_valid && ready_out;
            end
            if (valid_out && ready_out) obs_q.push_back(data_out);
        end
        if (pay_valid && pay_ready) pay_cnt++;
        if (!rst) begin
            m_known  = 1'b1;
            m_active = 1'b0;
            m_pos    = 0;
            m_pkt    = 16'd0;
            obs_q.delete();
        end else if (m_known) begin
            if (m_active) begin
                if (xfer) begin
                    if (m_pos == 0) first_cyc = cyc;
                    m_pos++;
                    if (m_pos == NW) begin
                        m_active = 1'b0;
                        m_pkt++;
                        pkts_done++;
                        done_cyc = cyc;
                        parser_check();
                        if (chk_span) check_eq("span", cyc - first_cyc, NW - 1);
                    end
                end
            end else if (start) begin
                if (b2b_mode && b2b_acc > 0) check_eq("b2b_gap", cyc - done_cyc, 1);
                if (b2b_mode) b2b_acc++;
                m_active   = 1'b1;
                m_pos      = 0;
                m_eth      = eth_hdr;
                m_ip       = ip_hdr;
                m_tcp      = tcp_hdr;
                m_pay_base = pay_base_next;
                pay_cnt    = 0;
                accepts++;
                obs_q.delete();
            end
        end
        @(posedge clk);
        #1;
        if (rst_hold > 0) begin
            rst = 1'b0;
            rst_hold--;
        end else if (rst_req && m_active && m_pos == 10) begin
            rst = 1'b0;
            rst_req = 1'b0;
        end else begin
            rst = 1'b1;
        end
        if (stall_cnt > 0) begin
            ready_out = 1'b0;
            stall_cnt--;
        end else if (stall_req && m_active && m_pos == 6) begin
            ready_out = 1'b0;
            stall_cnt = 2;
            stall_req = 1'b0;
        end else begin
            ready_out = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (gap_cnt > 0) begin
            pay_valid = 1'b0;
            gap_cnt--;
        end else if (gap_req && m_active && m_pos == 18) begin
            pay_valid = 1'b0;
            gap_cnt = 4;
            gap_req = 1'b0;
        end else begin
            pay_valid = rand_pay ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        pay_data = m_pay_base + 32'(pay_cnt);
        if (pulse_on) begin
            start = 1'b0;
            pulse_on = 1'b0;
        end else if (pulse_req && m_active && m_pos == 5) begin
            start = 1'b1;
            pulse_on = 1'b1;
            pulse_req = 1'b0;
            eth_hdr = {$urandom, $urandom, $urandom, $urandom};
            ip_hdr  = {$urandom, $urandom, $urandom, $urandom, $urandom};
            tcp_hdr = {$urandom, $urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic set_directed_hdrs();
        for (int k = 0; k < 4; k++) eth_hdr[32*k +: 32] = 32'hE000_0000 + 32'(k);
        for (int k = 0; k < 5; k++) begin
            ip_hdr[32*k +: 32]  = 32'h1000_0000 + 32'(k);
            tcp_hdr[32*k +: 32] = 32'h7000_0000 + 32'(k);
        end
    endtask

    task automatic run_until_done(input int target, input int budget);
        int n;
        n = 0;
        while (pkts_done < target && n < budget) begin
            step();
            n++;
        end
        check_eq("pkt_timeout", pkts_done, target);
    endtask

    task automatic send_one();
        int d0;
        d0 = pkts_done;
        start = 1'b1;
        step();
        start = 1'b0;
        run_until_done(d0 + 1, 400);
        repeat (2) step();
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; ready_out = 1'b1; pay_valid = 1'b0; pay_data = '0;
        eth_hdr = '0; ip_hdr = '0; tcp_hdr = '0;
        rst_hold = 1;
        repeat (3) step();

        // Basic packet with full FIFO and ready downstream.
        set_directed_hdrs();
        chk_span = 1;
        send_one();
        check_eq("pkt1_count", pkt_count, 16'd1);
        chk_span = 0;

        // Downstream stall on IP word 2.
        stall_req = 1;
        send_one();

        // FIFO underflow at payload word 4.
        gap_req = 1;
        send_one();

        // Start pulse with new headers during IP_HDR is ignored.
        set_directed_hdrs();
        pulse_req = 1;
        send_one();
        repeat (3) step();

        // Reset mid-packet in TCP_HDR, then a clean packet.
        set_directed_hdrs();
        rst_req = 1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 0; n < 100 && m_active; n++) step();
        step();
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_pkt_count", pkt_count, 16'd0);
        send_one();

        // Three back-to-back packets with start held high.
        chk_span = 1;
        b2b_mode = 1;
        b2b_acc  = 0;
        begin
            int d0, n;
            d0 = pkts_done;
            n = 0;
            start = 1'b1;
            while (b2b_acc < 3 && n < 400) begin
                step();
                n++;
            end
            start = 1'b0;
            check_eq("b2b_accepts", b2b_acc, 3);
            run_until_done(d0 + 3, 400);
        end
        b2b_mode = 0;
        chk_span = 0;
        check_eq("b2b_count", pkt_count, m_pkt);

        // Randomised traffic with header churn during packets.
        rand_ready = 1;
        rand_pay = 1;
        for (int p = 0; p < 15; p++) begin
            int d0;
            d0 = pkts_done;
            eth_hdr = {$urandom, $urandom, $urandom, $urandom};
            ip_hdr  = {$urandom, $urandom, $urandom, $urandom, $urandom};
            tcp_hdr = {$urandom, $urandom, $urandom, $urandom, $urandom};
            pay_base_next = $urandom;
            repeat ($urandom_range(0, 3)) step();
            start = 1'b1;
            step();
            start = 1'b0;
            eth_hdr = {$urandom, $urandom, $urandom, $urandom};
            ip_hdr  = {$urandom, $urandom, $urandom, $urandom, $urandom};
            run_until_done(d0 + 1, 600);
        end
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
